// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one 32-bit memory bus between instruction fetch and the data port.
// One transaction in flight at a time. The data port has priority, but fetch wins after STARVE_MAX consecutive losses.
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_e;
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;            // 1 = data port owns the bus
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_wstrb_q, bus_wstrb_d;
  logic [31:0]     if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic            if_err_q, if_err_d, d_err_q, d_err_d;

  logic        any_req, d_wins, timeout_hit, bus_done;
  logic [31:0] resp_rdata;

  assign any_req     = if_req | d_req;
  assign d_wins      = d_req & ~(if_req & (starve_cnt_q == 4'(STARVE_MAX)));
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign bus_done    = bus_ack | timeout_hit;
  // Stores and timeouts return zero data.
  assign resp_rdata  = (bus_ack && !bus_we_q) ? bus_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      to_cnt_q     <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_BUSY;
      S_BUSY:  if (bus_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    if_rdata_d   = if_rdata_q;
    if_err_d     = if_err_q;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          bus_req_d = 1'b1;
          owner_d   = d_wins;
          if (d_wins) begin
            bus_we_d    = d_we;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
            bus_wstrb_d = d_we ? d_wstrb : 4'b0000;
            if (if_req && (starve_cnt_q != 4'hF)) starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            bus_we_d     = 1'b0;
            bus_addr_d   = if_addr;
            bus_wdata_d  = '0;
            bus_wstrb_d  = 4'b0000;
            starve_cnt_d = '0;
          end
        end
      end
      S_BUSY: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus_done) begin
          bus_req_d = 1'b0;
          if (owner_q) begin
            d_rdata_d = resp_rdata;
            d_err_d   = ~bus_ack;
          end else begin
            if_rdata_d = resp_rdata;
            if_err_d   = ~bus_ack;
          end
        end
      end
      S_RESP:  to_cnt_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    if_ack = 1'b0;
    d_ack  = 1'b0;
    if (state_q == S_RESP) begin
      if_ack = ~owner_q;
      d_ack  = owner_q;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized accesses.
// Expected values come from a transaction-level model of the grant rule and the response data.
module tb_mem_bus_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  mem_bus_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference state: fetch-loss count and the last response each port has seen.
  int          losses_m = 0;
  logic [31:0] last_if_rd = '0, last_d_rd = '0;
  logic        last_if_err = 1'b0, last_d_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_if_ack"}, 32'(if_ack), 32'd0);
    check({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
  endtask

  // Called at the falling edge of an IDLE cycle with requests already driven.
  // ack_at = BUSY cycle index in which bus_ack is given; negative means never.
  task automatic access(input int ack_at, input logic [31:0] rd, input bit late_ack,
                        output bit obs_d);
    bit          dw, acked;
    logic [31:0] ea, ewd, erd;
    logic        ewe;
    logic [3:0]  es;
    dw    = d_req && !(if_req && losses_m == STARVE_MAX);
    acked = 1'b0;
    if (dw) begin
      ea = d_addr; ewe = d_we; ewd = d_wdata; es = d_we ? d_wstrb : 4'b0000;
      if (if_req && losses_m < 15) losses_m++;
    end else begin
      ea = if_addr; ewe = 1'b0; ewd = '0; es = 4'b0000;
      losses_m = 0;
    end
    @(negedge clk);
    for (int k = 0; k < TIMEOUT; k++) begin
      check("busy_bus_req", 32'(bus_req), 32'd1);
      check("busy_bus_addr", bus_addr, ea);
      check("busy_bus_we", 32'(bus_we), 32'(ewe));
      check("busy_bus_wstrb", 32'(bus_wstrb), 32'(es));
      if (ewe) check("busy_bus_wdata", bus_wdata, ewd);
      check("busy_acks", 32'({if_ack, d_ack}), 32'd0);
      if (k == ack_at) begin
        bus_ack = 1'b1; bus_rdata = rd;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    erd = (acked && !ewe) ? rd : 32'h0;
    if (dw) begin last_d_rd = erd; last_d_err = !acked; end
    else begin last_if_rd = erd; last_if_err = !acked; end
    obs_d = d_ack;
    check("resp_if_ack", 32'(if_ack), 32'(!dw));
    check("resp_d_ack", 32'(d_ack), 32'(dw));
    check("resp_if_rdata", if_rdata, last_if_rd);
    check("resp_if_err", 32'(if_err), 32'(last_if_err));
    check("resp_d_rdata", d_rdata, last_d_rd);
    check("resp_d_err", 32'(d_err), 32'(last_d_err));
    check("resp_bus_req", 32'(bus_req), 32'd0);
    if (late_ack) begin
      bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    check_quiet("idle");
    check("idle_d_rdata", d_rdata, last_d_rd);
    check("idle_if_rdata", if_rdata, last_if_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          od;
    string       order;
    logic [1:0]  r2;
    int          ack_at;

    // Reset held for two cycles with both ports requesting.
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wdata = '0; d_wstrb = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_quiet("rst");
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
    end
    rst = 1'b0;
    access(1, 32'h1111_2222, 1'b0, od);

    // Single load, then store with partial strobes.
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    access(2, 32'hDEAD_BEEF, 1'b0, od);
    d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234; d_wstrb = 4'b0011;
    access(2, 32'hFFFF_FFFF, 1'b0, od);

    // A lone fetch clears the fetch-loss count before the contention run.
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
    access(0, 32'hA5A5_0001, 1'b0, od);

    d_req = 1'b1; d_addr = 32'h0000_8000;
    order = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) begin
      access(0, $urandom, 1'b0, od);
      check("grant_order", 32'(od), 32'(order[i] == "D"));
    end

    // Timeout with a late bus_ack while the response is presented.
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
    access(-1, 32'h0, 1'b1, od);
    access(1, 32'h7777_8888, 1'b0, od);

    // Reset during a fetch in BUSY, with bus_ack in the same cycle.
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0300;
    @(negedge clk);
    check("mid_bus_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
    losses_m = 0; last_if_rd = '0; last_d_rd = '0; last_if_err = 1'b0; last_d_err = 1'b0;
    check_quiet("rst_busy");
    check("rst_busy_if_rdata", if_rdata, 32'd0);
    @(negedge clk);
    check_quiet("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r2 = 2'($urandom_range(0, 3));
      if_req = r2[0]; d_req = r2[1];
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_we = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom_range(0, 15));
      if (r2 == 2'b00) begin
        @(negedge clk);
        check_quiet("rand_idle");
      end else begin
        ack_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
        access(ack_at, $urandom, 1'($urandom_range(0, 1)), od);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
